// File: rtl/ifu_icd_pkg.sv
// Shared definitions for the S1 IFU I-cache fill assembler: the fill FSM
// states, the array slot and line geometry, and the opcode fields used by
// the CTI predecode.
package ifu_icd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRREQ   = 2'd2,
        WRDATA  = 2'd3
    } fill_state_t;

    localparam int SLOT_W     = 34;
    localparam int LINE_W     = 136;
    localparam int LINE_WORDS = 4;

    // Major opcode (data[31:30]) and op2 (data[24:22]) values for predecode
    localparam logic [1:0] OP_00   = 2'b00;
    localparam logic [1:0] OP_01   = 2'b01;
    localparam logic [2:0] OP2_100 = 3'b100;
    localparam logic [2:0] OP2_000 = 3'b000;

endpackage

// File: rtl/ifu_icd_fill_if.sv
// Bundle of the fill request/status, memory return path and I-cache data
// array write port. master = fill assembler, slave = its surroundings.
interface ifu_icd_fill_if
    import ifu_icd_pkg::*;
#(
    parameter int IDX_HI = 11,
    parameter int WAY_W  = 2
);

    logic                fill_start;
    logic [IDX_HI:4]     fill_index;
    logic [WAY_W-1:0]    fill_way;
    logic                busy;
    logic                fill_done;
    logic                fill_err;

    logic                rtn_vld;
    logic [31:0]         rtn_data;
    logic                rtn_err;
    logic                rtn_rdy;

    logic                icd_wrack;
    logic                icd_wrreq_bf;
    logic [IDX_HI:2]     icd_index_bf;
    logic [WAY_W-1:0]    icd_wrway_bf;
    logic [3:0]          icd_worden_bf;
    logic [LINE_W-1:0]   icd_wrdata_i2;

    modport master (
        input  fill_start, fill_index, fill_way,
        input  rtn_vld, rtn_data, rtn_err,
        input  icd_wrack,
        output busy, fill_done, fill_err,
        output rtn_rdy,
        output icd_wrreq_bf, icd_index_bf, icd_wrway_bf, icd_worden_bf, icd_wrdata_i2
    );

    modport slave (
        output fill_start, fill_index, fill_way,
        output rtn_vld, rtn_data, rtn_err,
        output icd_wrack,
        input  busy, fill_done, fill_err,
        input  rtn_rdy,
        input  icd_wrreq_bf, icd_index_bf, icd_wrway_bf, icd_worden_bf, icd_wrdata_i2
    );

endinterface

// File: rtl/ifu_icd_slotfmt.sv
// Formats one 32-bit instruction word into a 34-bit I-cache array slot:
// {parity, cti_predecode, data}. Parity is generated only when
// ICD_FILL_PARITY_EN is defined; otherwise the parity bit is tied to 0.
module ifu_icd_slotfmt
    import ifu_icd_pkg::*;
(
    input  logic [31:0]       data,
    output logic [SLOT_W-1:0] slot
);

    logic [1:0] op;
    logic [2:0] op2;
    logic       pdec;
    logic       par;

    assign op  = data[31:30];
    assign op2 = data[24:22];

    // CALL (op 01) is always a CTI; format-2 (op 00) is a branch unless op2
    // selects SETHI (100) or ILLTRAP (000)
    assign pdec = (op == OP_01) ||
                  ((op == OP_00) && (op2 != OP2_100) && (op2 != OP2_000));

`ifdef ICD_FILL_PARITY_EN
    // Even parity over data plus the predecode bit
    assign par = ^{pdec, data};
`else
    assign par = 1'b0;
`endif

    assign slot = {par, pdec, data};

endmodule

// File: rtl/ifu_icd_fill.sv
// I-cache fill assembler. Captures a fill request, collects four return
// words into a formatted 136-bit line, then issues one full-line write to
// the data array (skipped if any beat carried an error). Every output is
// either a register or a decode of the FSM state.
// Optional feature macro: ICD_FILL_PARITY_EN (slot parity, see slot formatter).
module ifu_icd_fill
    import ifu_icd_pkg::*;
#(
    parameter int IDX_HI = 11,
    parameter int WAY_W  = 2
)(
    input  logic          rclk,
    input  logic          reset_l,
    ifu_icd_fill_if.master bus
);

    fill_state_t       state;
    fill_state_t       state_nxt;
    logic [1:0]        beat_cnt;
    logic              err_flag;
    logic              beat_acc;
    logic              start_acc;
    logic [SLOT_W-1:0] slot;

    assign start_acc = (state == IDLE) && bus.fill_start;
    assign beat_acc  = (state == COLLECT) && bus.rtn_vld;

    ifu_icd_slotfmt u_slotfmt (
        .data (bus.rtn_data),
        .slot (slot)
    );

    // FSM state register
    always_ff @(posedge rclk or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake/status outputs
    always_comb begin
        state_nxt         = state;
        bus.busy          = 1'b1;
        bus.rtn_rdy       = 1'b0;
        bus.icd_wrreq_bf  = 1'b0;
        bus.icd_worden_bf = 4'h0;
        bus.fill_done     = 1'b0;
        bus.fill_err      = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.fill_start) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                bus.rtn_rdy = 1'b1;
                if (bus.rtn_vld && (beat_cnt == 2'd3)) begin
                    state_nxt = (err_flag || bus.rtn_err) ? WRDATA : WRREQ;
                end
            end
            WRREQ: begin
                bus.icd_wrreq_bf  = 1'b1;
                bus.icd_worden_bf = 4'hF;
                if (bus.icd_wrack) begin
                    state_nxt = WRDATA;
                end
            end
            WRDATA: begin
                bus.fill_done = 1'b1;
                bus.fill_err  = err_flag;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, beat counting, sticky error and line assembly
    always_ff @(posedge rclk or negedge reset_l) begin
        if (!reset_l) begin
            bus.icd_index_bf  <= '0;
            bus.icd_wrway_bf  <= '0;
            bus.icd_wrdata_i2 <= '0;
            beat_cnt          <= 2'd0;
            err_flag          <= 1'b0;
        end else if (start_acc) begin
            bus.icd_index_bf <= {bus.fill_index, 2'b00};
            bus.icd_wrway_bf <= bus.fill_way;
            beat_cnt         <= 2'd0;
            err_flag         <= 1'b0;
        end else if (beat_acc) begin
            bus.icd_wrdata_i2[int'(beat_cnt)*SLOT_W +: SLOT_W] <= slot;
            beat_cnt <= beat_cnt + 2'd1;
            err_flag <= err_flag | bus.rtn_err;
        end
    end

endmodule

// File: tb/tb_ifu_icd_fill.sv
// Self-checking bench for ifu_icd_fill. A behavioural model derives the
// expected line from the predecode/parity rules and the expected cycle
// timing from the beat gaps and ack delay.
module tb_ifu_icd_fill;

    localparam int IDX_HI = 11;
    localparam int WAY_W  = 2;

    logic rclk;
    logic reset_l;
    int   vectors     = 0;
    int   miscompares = 0;

    typedef struct {
        int           req_c;
        int           req_cycles;
        bit           unstable;
        int           done_c;
        logic         done_err;
        logic [135:0] line_done;
        logic [9:0]   idx_req;
        logic [1:0]   way_req;
        logic [3:0]   worden_req;
        bit           idle_after;
        bit           timeout;
    } fill_obs_t;

    ifu_icd_fill_if #(.IDX_HI(IDX_HI), .WAY_W(WAY_W)) bus ();

    ifu_icd_fill #(.IDX_HI(IDX_HI), .WAY_W(WAY_W)) dut (
        .rclk    (rclk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference predecode: CALL, or a format-2 op that is neither SETHI nor ILLTRAP
    function automatic logic ref_pdec(input logic [31:0] w);
        case (w[31:30])
            2'b01:   return 1'b1;
            2'b00:   return !(w[24:22] inside {3'b100, 3'b000});
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [135:0] ref_line(input logic [3:0][31:0] words);
        logic [135:0] line;
        logic         pd;
        logic         par;
        line = '0;
        for (int k = 0; k < 4; k++) begin
            pd = ref_pdec(words[k]);
`ifdef ICD_FILL_PARITY_EN
            par = ^{pd, words[k]};
`else
            par = 1'b0;
`endif
            line[k*34 +: 34] = {par, pd, words[k]};
        end
        return line;
    endfunction

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fill_start = 1'b0;
        bus.fill_index = '0;
        bus.fill_way   = '0;
        bus.rtn_vld    = 1'b0;
        bus.rtn_data   = '0;
        bus.rtn_err    = 1'b0;
        bus.icd_wrack  = 1'b0;
    endtask

    // Drives one fill starting in the current cycle (cycle 0) and records what
    // the array port and status outputs did; returns in the cycle after fill_done
    task automatic do_fill(input logic [7:0] idx, input logic [1:0] way,
                           input logic [3:0][31:0] words, input logic [3:0] errs,
                           input logic [3:0][3:0] gaps, input int ack_dly,
                           input bit stray_ack, input bit restart,
                           output fill_obs_t o);
        int           beat;
        int           gcnt;
        bit           vld;
        logic         rdy;
        logic [135:0] snap_line;
        o.req_c = -1; o.req_cycles = 0; o.unstable = 0; o.done_c = -1;
        o.done_err = 1'bx; o.line_done = '0; o.idx_req = '0; o.way_req = '0;
        o.worden_req = '0; o.idle_after = 0; o.timeout = 0;
        snap_line = '0;
        bus.fill_start = 1'b1;
        bus.fill_index = idx;
        bus.fill_way   = way;
        bus.rtn_vld    = 1'b0;
        bus.icd_wrack  = 1'b0;
        step();
        bus.fill_start = 1'b0;
        bus.fill_index = 8'($urandom);
        bus.fill_way   = 2'($urandom);
        beat = 0;
        gcnt = 0;
        for (int c = 1; c <= 300; c++) begin
            if (bus.icd_wrreq_bf) begin
                o.req_cycles++;
                if (o.req_c < 0) begin
                    o.req_c      = c;
                    snap_line    = bus.icd_wrdata_i2;
                    o.idx_req    = bus.icd_index_bf;
                    o.way_req    = bus.icd_wrway_bf;
                    o.worden_req = bus.icd_worden_bf;
                end else if (snap_line !== bus.icd_wrdata_i2 || o.idx_req !== bus.icd_index_bf ||
                             o.way_req !== bus.icd_wrway_bf || o.worden_req !== bus.icd_worden_bf) begin
                    o.unstable = 1;
                end
                if (bus.rtn_rdy || !bus.busy || bus.fill_done) o.unstable = 1;
            end
            if (bus.fill_done) begin
                o.done_c    = c;
                o.done_err  = bus.fill_err;
                o.line_done = bus.icd_wrdata_i2;
                break;
            end
            if (restart && c == 2) begin
                bus.fill_start = 1'b1;
                bus.fill_index = 8'h11;
                bus.fill_way   = ~way;
            end else begin
                bus.fill_start = 1'b0;
            end
            vld = 0;
            if (beat < 4) begin
                if (gcnt < int'(gaps[beat])) gcnt++;
                else vld = 1;
            end
            bus.rtn_vld = vld;
            if (vld) begin
                bus.rtn_data = words[beat];
                bus.rtn_err  = errs[beat];
            end else begin
                bus.rtn_data = $urandom;
                bus.rtn_err  = 1'($urandom);
            end
            if (bus.icd_wrreq_bf) bus.icd_wrack = (o.req_cycles > ack_dly);
            else                  bus.icd_wrack = stray_ack;
            rdy = bus.rtn_rdy;
            step();
            if (vld && rdy) begin
                beat++;
                gcnt = 0;
            end
        end
        if (o.done_c < 0) o.timeout = 1;
        idle_inputs();
        step();
        o.idle_after = !bus.busy && !bus.fill_done && !bus.icd_wrreq_bf && !bus.rtn_rdy;
    endtask

    task automatic test_reset();
        reset_l        = 1'b0;
        bus.fill_start = 1'b1;
        bus.fill_index = 8'hFF;
        bus.fill_way   = 2'd3;
        bus.rtn_vld    = 1'b1;
        bus.rtn_data   = 32'hFFFF_FFFF;
        bus.rtn_err    = 1'b1;
        bus.icd_wrack  = 1'b1;
        repeat (3) step();
        vectors++;
        if ({bus.busy, bus.rtn_rdy, bus.icd_wrreq_bf, bus.fill_done, bus.fill_err} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got %b expected 00000",
                     {bus.busy, bus.rtn_rdy, bus.icd_wrreq_bf, bus.fill_done, bus.fill_err});
        end
        vectors++;
        if ({bus.icd_index_bf, bus.icd_wrway_bf, bus.icd_worden_bf} !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_port: got %h expected 0000",
                     {bus.icd_index_bf, bus.icd_wrway_bf, bus.icd_worden_bf});
        end
        vectors++;
        if (bus.icd_wrdata_i2 !== 136'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_wrdata: got %h expected 0", bus.icd_wrdata_i2);
        end
        idle_inputs();
        reset_l = 1'b1;
        step();
    endtask

    task automatic test_clean_fill();
        logic [3:0][31:0] w;
        fill_obs_t        o;
        w[0] = 32'h40000010;
        w[1] = 32'h01000000;
        w[2] = 32'h9DE3BFA0;
        w[3] = 32'h10800004;
        do_fill(8'h3A, 2'd2, w, 4'b0000, '0, 0, 1'b0, 1'b0, o);
        vectors++;
        if (o.req_c !== 5) begin
            miscompares++; $display("[TB] FAIL clean_req_cycle: got %0d expected 5", o.req_c);
        end
        vectors++;
        if ({o.idx_req, o.way_req, o.worden_req} !== {10'h0E8, 2'd2, 4'hF}) begin
            miscompares++;
            $display("[TB] FAIL clean_req_fields: got idx %h way %0d worden %h expected idx 0e8 way 2 worden f",
                     o.idx_req, o.way_req, o.worden_req);
        end
        vectors++;
        if ({o.line_done[3*34+32], o.line_done[2*34+32], o.line_done[34+32], o.line_done[32]} !== 4'b1001) begin
            miscompares++;
            $display("[TB] FAIL clean_predecode: got %b expected 1001",
                     {o.line_done[3*34+32], o.line_done[2*34+32], o.line_done[34+32], o.line_done[32]});
        end
        vectors++;
        if (o.line_done !== ref_line(w)) begin
            miscompares++; $display("[TB] FAIL clean_line: got %h expected %h", o.line_done, ref_line(w));
        end
        vectors++;
        if ({o.done_c, o.done_err, o.idle_after} !== {32'd6, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL clean_done: got cycle %0d err %b idle_after %0d expected cycle 6 err 0 idle_after 1",
                     o.done_c, o.done_err, o.idle_after);
        end
    endtask

    task automatic test_error_beat();
        logic [3:0][31:0] w;
        fill_obs_t        o;
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        do_fill(8'($urandom), 2'($urandom), w, 4'b0100, '0, 0, 1'b0, 1'b0, o);
        vectors++;
        if (o.req_cycles !== 0) begin
            miscompares++; $display("[TB] FAIL err_no_wrreq: got %0d request cycles expected 0", o.req_cycles);
        end
        vectors++;
        if ({o.done_c, o.done_err, o.idle_after} !== {32'd5, 1'b1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL err_done: got cycle %0d err %b idle_after %0d expected cycle 5 err 1 idle_after 1",
                     o.done_c, o.done_err, o.idle_after);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0][31:0] w;
        logic [3:0][3:0]  g;
        fill_obs_t        o;
        for (int k = 0; k < 4; k++) begin
            w[k] = $urandom;
            g[k] = 4'd3;
        end
        do_fill(8'hC5, 2'd1, w, 4'b0000, g, 5, 1'b0, 1'b0, o);
        vectors++;
        if ({o.req_c, o.req_cycles, o.unstable} !== {32'd17, 32'd6, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL bp_request: got start %0d len %0d unstable %0d expected start 17 len 6 unstable 0",
                     o.req_c, o.req_cycles, o.unstable);
        end
        vectors++;
        if ({o.done_c, o.done_err} !== {32'd23, 1'b0}) begin
            miscompares++; $display("[TB] FAIL bp_done: got cycle %0d err %b expected cycle 23 err 0", o.done_c, o.done_err);
        end
        vectors++;
        if (o.line_done !== ref_line(w)) begin
            miscompares++; $display("[TB] FAIL bp_line: got %h expected %h", o.line_done, ref_line(w));
        end
    endtask

    task automatic test_start_while_busy();
        logic [3:0][31:0] w;
        fill_obs_t        o;
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        do_fill(8'h6B, 2'd0, w, 4'b0000, '0, 0, 1'b0, 1'b1, o);
        vectors++;
        if ({o.idx_req, o.way_req} !== {10'h1AC, 2'd0}) begin
            miscompares++;
            $display("[TB] FAIL busy_start_index: got idx %h way %0d expected idx 1ac way 0", o.idx_req, o.way_req);
        end
        vectors++;
        if ({o.done_c, o.idle_after} !== {32'd6, 1'b1} || o.line_done !== ref_line(w)) begin
            miscompares++;
            $display("[TB] FAIL busy_start_done: got cycle %0d idle_after %0d line %h expected cycle 6 idle_after 1 line %h",
                     o.done_c, o.idle_after, o.line_done, ref_line(w));
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [3:0][31:0] w;
        fill_obs_t        o;
        bit               bad;
        bus.fill_start = 1'b1;
        bus.fill_index = 8'h5C;
        bus.fill_way   = 2'd3;
        step();
        bus.fill_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.rtn_vld  = 1'b1;
            bus.rtn_data = $urandom;
            bus.rtn_err  = 1'b1;
            step();
        end
        bus.rtn_vld = 1'b0;
        bus.rtn_err = 1'b0;
        reset_l = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.rtn_rdy, bus.icd_wrreq_bf, bus.fill_done, bus.fill_err,
             bus.icd_index_bf, bus.icd_wrway_bf, bus.icd_worden_bf} !== 21'h0 || bus.icd_wrdata_i2 !== 136'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got busy %b rdy %b idx %h way %0d data %h expected all zero",
                     bus.busy, bus.rtn_rdy, bus.icd_index_bf, bus.icd_wrway_bf, bus.icd_wrdata_i2);
        end
        step();
        reset_l = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            bus.rtn_vld   = 1'b1;
            bus.rtn_data  = $urandom;
            bus.icd_wrack = 1'b1;
            step();
            if (bus.fill_done || bus.busy || bus.icd_wrreq_bf) bad = 1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midreset_quiet: got activity %0d expected 0", bad);
        end
        idle_inputs();
        step();
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        do_fill(8'h27, 2'd1, w, 4'b0000, '0, 0, 1'b0, 1'b0, o);
        vectors++;
        if ({o.done_c, o.done_err, o.idx_req} !== {32'd6, 1'b0, 10'h09C} || o.line_done !== ref_line(w)) begin
            miscompares++;
            $display("[TB] FAIL midreset_refill: got cycle %0d err %b idx %h line %h expected cycle 6 err 0 idx 09c line %h",
                     o.done_c, o.done_err, o.idx_req, o.line_done, ref_line(w));
        end
    endtask

    task automatic test_stray();
        logic [3:0][31:0] w;
        fill_obs_t        o;
        for (int k = 0; k < 4; k++) begin
            bus.rtn_vld  = 1'b1;
            bus.rtn_data = $urandom;
            step();
            vectors++;
            if ({bus.rtn_rdy, bus.busy} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL stray_idle_rdy: got rdy %b busy %b expected rdy 0 busy 0", bus.rtn_rdy, bus.busy);
            end
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        do_fill(8'h90, 2'd3, w, 4'b0000, '0, 2, 1'b1, 1'b0, o);
        vectors++;
        if ({o.req_c, o.req_cycles, o.done_c} !== {32'd5, 32'd3, 32'd8} || o.line_done !== ref_line(w)) begin
            miscompares++;
            $display("[TB] FAIL stray_fill: got req %0d len %0d done %0d line %h expected req 5 len 3 done 8 line %h",
                     o.req_c, o.req_cycles, o.done_c, o.line_done, ref_line(w));
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0][31:0] w;
        fill_obs_t        o;
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 4; k++) w[k] = $urandom;
            do_fill(8'(8'h40 + n), 2'(n), w, 4'b0000, '0, 0, 1'b0, 1'b0, o);
            vectors++;
            if ({o.req_c, o.done_c, o.idx_req} !== {32'd5, 32'd6, 8'(8'h40 + n), 2'b00} || o.line_done !== ref_line(w)) begin
                miscompares++;
                $display("[TB] FAIL b2b_fill%0d: got req %0d done %0d idx %h expected req 5 done 6 idx %h",
                         n, o.req_c, o.done_c, o.idx_req, {8'(8'h40 + n), 2'b00});
            end
        end
    endtask

    task automatic test_random();
        logic [3:0][31:0] w;
        logic [3:0][3:0]  g;
        logic [3:0]       e;
        logic [7:0]       idx;
        logic [1:0]       way;
        int               ack;
        int               last;
        fill_obs_t        o;
        for (int n = 0; n < 10; n++) begin
            last = 0;
            for (int k = 0; k < 4; k++) begin
                w[k] = $urandom;
                g[k] = 4'($urandom_range(0, 3));
                e[k] = ($urandom_range(0, 7) == 0);
                last += int'(g[k]) + 1;
            end
            idx = 8'($urandom);
            way = 2'($urandom);
            ack = $urandom_range(0, 4);
            do_fill(idx, way, w, e, g, ack, 1'($urandom), 1'b0, o);
            vectors++;
            if (|e) begin
                if ({o.req_cycles, o.done_c, o.done_err, o.idle_after} !== {32'd0, 32'(last + 1), 1'b1, 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_err: got len %0d done %0d err %b idle %0d expected len 0 done %0d err 1 idle 1",
                             n, o.req_cycles, o.done_c, o.done_err, o.idle_after, last + 1);
                end
            end else begin
                if ({o.req_c, o.req_cycles, o.done_c, o.done_err, o.unstable, o.idx_req, o.way_req, o.worden_req} !==
                    {32'(last + 1), 32'(ack + 1), 32'(last + ack + 2), 1'b0, 1'b0, idx, 2'b00, way, 4'hF} ||
                    o.line_done !== ref_line(w)) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_fill: got req %0d len %0d done %0d idx %h way %0d line %h expected req %0d len %0d done %0d idx %h way %0d line %h",
                             n, o.req_c, o.req_cycles, o.done_c, o.idx_req, o.way_req, o.line_done,
                             last + 1, ack + 1, last + ack + 2, {idx, 2'b00}, way, ref_line(w));
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset_l = 1'b1;
        test_reset();
        test_clean_fill();
        test_error_beat();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_fill();
        test_stray();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifu_icd_fill.md
# ifu_icd_fill

Instruction-cache fill assembler for the S1 core IFU. Accepts a fill request (line index, way), collects four 32-bit instruction words from the memory return path, then formats each word into a 34-bit array slot (data, CTI predecode, parity) and issues one full-line write request to the I-cache data array. Sits directly upstream of the data array write port: it drives the array's write index, way, word enables, write request and 136-bit write data.

## Interface
- `IDX_HI`, default 11: top bit of the array index.
- `WAY_W`, default 2: way-select width.
- `rclk` in 1: clock; all state rises on posedge.
- `reset_l` in 1: asynchronous active-low reset.
- `fill_start` in 1: fill request strobe; taken only when `busy`=0.
- `fill_index` in [IDX_HI:4]: line index, captured with `fill_start`.
- `fill_way` in [WAY_W-1:0]: target way, captured with `fill_start`.
- `rtn_vld` in 1: return word valid.
- `rtn_data` in 32: return word.
- `rtn_err` in 1: return word carries an uncorrectable error.
- `rtn_rdy` out 1: return word accepted when `rtn_vld`&`rtn_rdy`.
- `icd_wrack` in 1: array grants the write this cycle.
- `icd_wrreq_bf` out 1: array write request.
- `icd_index_bf` out [IDX_HI:2]: {line index, 2'b00}.
- `icd_wrway_bf` out [WAY_W-1:0]: captured way.
- `icd_worden_bf` out 4: word enables.
- `icd_wrdata_i2` out 136: formatted line.
- `busy` out 1: fill in progress.
- `fill_done` out 1: one-cycle completion pulse.
- `fill_err` out 1: qualifies `fill_done`; line was not written.

## Operation
- FSM states: IDLE, COLLECT, WRREQ, WRDATA.
- IDLE: `busy`=0, `rtn_rdy`=0. `fill_start` captures index and way, clears word counter and error flag, and moves to COLLECT. Return beats in IDLE are ignored and not acknowledged.
- COLLECT: `rtn_rdy`=1. Each accepted beat k (2-bit counter, 0..3) is formatted into slot k = bits [34k+33:34k]:
  - bit 31:0 = data.
  - bit 32 = CTI predecode: 1 if data[31:30]==01, or if data[31:30]==00 and data[24:22] is not 100 and not 000.
  - bit 33 = parity (see Configuration).
  - `rtn_err` sets a sticky error flag.
- After beat 3: go to WRREQ, or go to WRDATA with the error flag set (the write is skipped).
- WRREQ: `icd_wrreq_bf`=1, `icd_worden_bf`=4'hF. The request is held until `icd_wrack`, then the FSM moves to WRDATA.
- WRDATA: `fill_done`=1 and `fill_err`=error flag. `icd_wrdata_i2` is held stable from the end of COLLECT through this cycle. Next state is IDLE.
- `fill_start` while `busy`=1 is ignored and does not queue.
- `icd_wrack` outside WRREQ is ignored.
- Reset asserted mid-fill: all state is cleared immediately, no write and no `fill_done` are produced, and partial data is discarded.
- Reset values: `busy`, `rtn_rdy`, `icd_wrreq_bf`, `fill_done`, `fill_err` = 0; `icd_index_bf`, `icd_wrway_bf`, `icd_worden_bf`, `icd_wrdata_i2` = 0.

## Timing
- All outputs are registered or decoded from FSM state only; there is no input-to-output combinational path.
- Write data is registered and stable one cycle after the write request is granted (i2 = bf+1).
- Minimum latency: `fill_start` in cycle 0; beats in cycles 1–4; WRREQ with ack in cycle 5; `fill_done` in cycle 6; IDLE and `busy`=0 in cycle 7. A new `fill_start` is accepted in cycle 7.
- Gaps in `rtn_vld` stall COLLECT. Ack delay stalls WRREQ with all outputs unchanged.

## Configuration
- `ICD_FILL_PARITY_EN` defined: slot bit 33 = XOR of slot bits 32:0 (even parity over data plus predecode).
- `ICD_FILL_PARITY_EN` not defined: slot bit 33 = 0 and the parity logic is absent.

## Structure
- Shared package `ifu_icd_pkg`:
  - FSM state enum.
  - Slot width constant (34) and line width constant (136).
  - Predecode opcode constants (op 00/01, op2 100/000).
- Sub-module `ifu_icd_slotfmt`: combinational word formatter (32 → 34 bits) with predecode and conditional parity. Instantiated once, on the accepted beat.

## Test plan
- Clean fill: index 0x3A, way 2; words 0x40000010, 0x01000000, 0x9DE3BFA0, 0x10800004; immediate ack.
  - Required: wrreq in cycle 5 with `icd_index_bf`=0x3A<<2, way 2, worden F.
  - Required predecode bits 1,0,0,1; `fill_done` in cycle 6 with `fill_err`=0; parity per the macro.
- Error beat: `rtn_err`=1 on beat 2.
  - Required: `icd_wrreq_bf` never asserts; `fill_done`=1 and `fill_err`=1 in the cycle after beat 3.
- Back-pressure: `rtn_vld` gaps of 3 cycles between beats and ack delayed 5 cycles.
  - Required: request and data held constant; `fill_done` only after ack.
- `fill_start` during COLLECT with index 0x11.
  - Required: ignored; the write uses the original index.
- Reset pulse after beat 2.
  - Required: all outputs return to 0 and no `fill_done`; a subsequent fill completes normally.
- Stray `rtn_vld` in IDLE and stray `icd_wrack` in COLLECT.
  - Required: `rtn_rdy`=0 in IDLE, beat not counted, no state change.
